// File: rtl/eth_fcs_append_ctrl_pkg.sv
// Shared types and constants for the Ethernet FCS append controller.
// Holds the FSM state encoding, the output beat payload struct and the
// CRC-32 polynomial/initial value used by the CRC engine.
package eth_fcs_append_ctrl_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CRC_W  = 32;

    localparam logic [CRC_W-1:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [CRC_W-1:0] CRC32_INIT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_PAD     = 2'd2,
        ST_FCS     = 2'd3
    } state_t;

    // One output beat as held in the output register.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              user;
    } beat_t;

endpackage

// File: rtl/eth_fcs_append_ctrl_if.sv
// 8-bit AXI4-Stream byte channel used on both sides of the FCS append block.
// Signals: tdata (byte), tvalid, tready, tlast (end of frame), tuser (bad frame).
// Modports: master drives tdata/tvalid/tlast/tuser, slave drives tready.
interface eth_fcs_append_ctrl_if;
    import eth_fcs_append_ctrl_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/ve_lfsr.sv
// Combinational LFSR/CRC step: advances state_in by DATA_WIDTH input bits.
// Ports: data_in (bits shifted in), state_in (current state),
//        state_out (state after all data bits).
// REVERSE=1 processes data LSB-first with a right-shifting (reflected) register;
// it is realised by bit-reversing around the forward, MSB-first core.
module ve_lfsr #(
    parameter int unsigned          LFSR_WIDTH        = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY        = 32'h04C11DB7,
    parameter string                LFSR_CONFIG       = "GALOIS",
    parameter bit                   LFSR_FEED_FORWARD = 1'b0,
    parameter bit                   REVERSE           = 1'b1,
    parameter int unsigned          DATA_WIDTH        = 8
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [LFSR_WIDTH-1:0] state_out
);

    function automatic logic [LFSR_WIDTH-1:0] rev_state(input logic [LFSR_WIDTH-1:0] x);
        logic [LFSR_WIDTH-1:0] r;
        for (int k = 0; k < int'(LFSR_WIDTH); k++) begin
            r[k] = x[int'(LFSR_WIDTH) - 1 - k];
        end
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rev_data(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] r;
        for (int k = 0; k < int'(DATA_WIDTH); k++) begin
            r[k] = x[int'(DATA_WIDTH) - 1 - k];
        end
        return r;
    endfunction

    logic [LFSR_WIDTH-1:0] st;
    logic [DATA_WIDTH-1:0] dv;
    logic                  tap;
    logic                  fb;

    // Bit-serial loop unrolled into one combinational step.
    always_comb begin
        st  = REVERSE ? rev_state(state_in) : state_in;
        dv  = REVERSE ? rev_data(data_in) : data_in;
        tap = 1'b0;
        fb  = 1'b0;
        for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
            if (LFSR_CONFIG == "GALOIS") begin
                tap = st[LFSR_WIDTH-1];
            end else begin
                tap = ^(st & LFSR_POLY);
            end
            // Feed-forward mode keeps data out of the register (scrambler form).
            fb = LFSR_FEED_FORWARD ? tap : (tap ^ dv[i]);
            if (LFSR_CONFIG == "GALOIS") begin
                st = {st[LFSR_WIDTH-2:0], 1'b0} ^ (fb ? LFSR_POLY : '0);
            end else begin
                st = {st[LFSR_WIDTH-2:0], fb};
            end
        end
        state_out = REVERSE ? rev_state(st) : st;
    end

endmodule

// File: rtl/eth_fcs_append_ctrl.sv
// Ethernet TX frame sequencer: passes payload bytes, optionally zero-pads
// short frames to MIN_FRAME_LENGTH (FCS included) and appends the CRC-32 FCS.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   s_axis       payload input (slave modport); tuser sampled with tlast
//   m_axis       framed output (master modport); tlast on final FCS byte,
//                tuser = bad-frame flag on that byte only
//   busy         high from first accepted byte until the tlast handshake
module eth_fcs_append_ctrl
    import eth_fcs_append_ctrl_pkg::*;
#(
    parameter bit          ENABLE_PADDING   = 1'b1,
    parameter int unsigned MIN_FRAME_LENGTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    eth_fcs_append_ctrl_if.slave         s_axis,
    eth_fcs_append_ctrl_if.master        m_axis,
    output logic                         busy
);

    localparam int unsigned      CNT_W   = $clog2(MIN_FRAME_LENGTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_FRAME_LENGTH - 4);

    state_t             state, state_next;
    logic [CRC_W-1:0]   crc_state, crc_next, crc_upd;
    logic [CRC_W-1:0]   fcs_reg, fcs_next;
    logic [CNT_W-1:0]   byte_cnt, cnt_next, cnt_inc;
    logic [1:0]         fcs_idx, idx_next;
    logic               bad_reg, bad_next;
    beat_t              out_q, out_next;
    logic               out_valid, valid_next;
    logic               busy_next;
    logic [DATA_W-1:0]  lfsr_data;
    logic               load, s_ready, s_fire, m_fire;

    // Output register may take a new beat when empty or being drained.
    assign load    = !out_valid || m_axis.tready;
    assign s_ready = !rst && load && (state == ST_IDLE || state == ST_PAYLOAD);
    assign s_fire  = s_axis.tvalid && s_ready;
    assign m_fire  = out_valid && m_axis.tready;

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = out_q.data;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_q.last;
    assign m_axis.tuser  = out_q.user;

    // Pad beats feed zero bytes into the CRC.
    assign lfsr_data = (state == ST_PAD) ? '0 : s_axis.tdata;

    ve_lfsr #(
        .LFSR_WIDTH        (CRC_W),
        .LFSR_POLY         (CRC32_POLY),
        .LFSR_CONFIG       ("GALOIS"),
        .LFSR_FEED_FORWARD (1'b0),
        .REVERSE           (1'b1),
        .DATA_WIDTH        (DATA_W)
    ) u_crc (
        .data_in   (lfsr_data),
        .state_in  (crc_state),
        .state_out (crc_upd)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            crc_state <= CRC32_INIT;
            fcs_reg   <= '0;
            byte_cnt  <= '0;
            fcs_idx   <= '0;
            bad_reg   <= 1'b0;
            out_q     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            crc_state <= crc_next;
            fcs_reg   <= fcs_next;
            byte_cnt  <= cnt_next;
            fcs_idx   <= idx_next;
            bad_reg   <= bad_next;
            out_q     <= out_next;
            out_valid <= valid_next;
            busy      <= busy_next;
        end
    end

    // Next-state and datapath update; nothing advances unless the output loads.
    always_comb begin
        state_next = state;
        crc_next   = crc_state;
        fcs_next   = fcs_reg;
        cnt_next   = byte_cnt;
        idx_next   = fcs_idx;
        bad_next   = bad_reg;
        out_next   = out_q;
        valid_next = out_valid;
        busy_next  = busy;
        cnt_inc    = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + CNT_W'(1);

        if (load) begin
            valid_next    = 1'b0;
            out_next.last = 1'b0;
            out_next.user = 1'b0;
        end

        // A new frame starting in the tlast-handshake cycle keeps busy high.
        if (s_fire) begin
            busy_next = 1'b1;
        end else if (m_fire && out_q.last) begin
            busy_next = 1'b0;
        end

        case (state)
            ST_IDLE, ST_PAYLOAD: begin
                if (s_fire) begin
                    out_next.data = s_axis.tdata;
                    valid_next    = 1'b1;
                    crc_next      = crc_upd;
                    cnt_next      = cnt_inc;
                    state_next    = ST_PAYLOAD;
                    if (s_axis.tlast) begin
                        bad_next = s_axis.tuser;
                        if (ENABLE_PADDING && ((byte_cnt + CNT_W'(1)) < CNT_MAX)) begin
                            state_next = ST_PAD;
                        end else begin
                            state_next = ST_FCS;
                            idx_next   = '0;
                            fcs_next   = ~crc_upd;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (load) begin
                    out_next.data = '0;
                    valid_next    = 1'b1;
                    crc_next      = crc_upd;
                    cnt_next      = cnt_inc;
                    if ((byte_cnt + CNT_W'(1)) == CNT_MAX) begin
                        state_next = ST_FCS;
                        idx_next   = '0;
                        fcs_next   = ~crc_upd;
                    end
                end
            end
            ST_FCS: begin
                if (load) begin
                    out_next.data = fcs_reg[{fcs_idx, 3'b000} +: DATA_W];
                    valid_next    = 1'b1;
                    if (fcs_idx == 2'd3) begin
                        out_next.last = 1'b1;
                        out_next.user = bad_reg;
                        crc_next      = CRC32_INIT;
                        cnt_next      = '0;
                        state_next    = ST_IDLE;
                    end else begin
                        idx_next = fcs_idx + 2'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_eth_fcs_append_ctrl.sv
// Directed bench for eth_fcs_append_ctrl: one padding instance and one
// non-padding instance sharing clock and reset.
module tb_eth_fcs_append_ctrl;
    import eth_fcs_append_ctrl_pkg::*;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [9:0] beat_q_t[$];   // {user, last, data}

    logic clk = 1'b0;
    logic rst;
    logic busy_pad, busy_np;
    int   total = 0;
    int   bad   = 0;
    bit   rdy_rand = 1'b0;

    beat_q_t    got_pad;
    beat_q_t    got_np;
    logic [10:0] prev_beat [2];
    bit          prev_stall [2];

    eth_fcs_append_ctrl_if sp();
    eth_fcs_append_ctrl_if mp();
    eth_fcs_append_ctrl_if sn();
    eth_fcs_append_ctrl_if mn();

    eth_fcs_append_ctrl #(.ENABLE_PADDING(1'b1), .MIN_FRAME_LENGTH(64)) dut_pad (
        .clk    (clk),
        .rst    (rst),
        .s_axis (sp.slave),
        .m_axis (mp.master),
        .busy   (busy_pad)
    );

    eth_fcs_append_ctrl #(.ENABLE_PADDING(1'b0), .MIN_FRAME_LENGTH(64)) dut_np (
        .clk    (clk),
        .rst    (rst),
        .s_axis (sn.slave),
        .m_axis (mn.master),
        .busy   (busy_np)
    );

    always #5 clk = ~clk;

    // Downstream ready: constant 1 or 50% random.
    always @(posedge clk) begin
        #1;
        mp.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        mn.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Capture handshakes and verify outputs hold while stalled.
    task automatic mon(input int d, input logic v, input logic r, input logic [9:0] beat);
        if (rst) begin
            prev_stall[d] = 1'b0;
            return;
        end
        if (prev_stall[d]) check($sformatf("hold%0d", d), 32'({v, beat}), 32'(prev_beat[d]));
        if (v && r) begin
            if (d == 0) got_pad.push_back(beat);
            else        got_np.push_back(beat);
        end
        prev_stall[d] = v && !r;
        prev_beat[d]  = {v, beat};
    endtask

    always @(negedge clk) begin
        mon(0, mp.tvalid, mp.tready, {mp.tuser, mp.tlast, mp.tdata});
        mon(1, mn.tvalid, mn.tready, {mn.tuser, mn.tlast, mn.tdata});
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    // Reference framing: payload, zero pad to 60 if enabled, FCS LSB first.
    task automatic build_exp(input byte_q_t pl, input bit pad, input logic u, inout beat_q_t e);
        logic [31:0] c;
        int n;
        c = 32'hFFFFFFFF;
        n = 0;
        foreach (pl[i]) begin
            e.push_back({2'b00, pl[i]});
            c = crc_byte(c, pl[i]);
            n++;
        end
        while (pad && n < 60) begin
            e.push_back(10'h000);
            c = crc_byte(c, 8'h00);
            n++;
        end
        c = ~c;
        for (int k = 0; k < 4; k++) e.push_back({u & (k == 3), 1'(k == 3), c[8*k +: 8]});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic [7:0] data, input logic v, input logic l, input logic u);
        if (d == 0) begin
            sp.tdata = data; sp.tvalid = v; sp.tlast = l; sp.tuser = u;
        end else begin
            sn.tdata = data; sn.tvalid = v; sn.tlast = l; sn.tuser = u;
        end
    endtask

    function automatic logic s_rdy(input int d);
        return (d == 0) ? sp.tready : sn.tready;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the last handshake.
    task automatic send_frame(input int d, input byte_q_t pl, input logic u);
        int  waited;
        bit  ok;
        for (int i = 0; i < pl.size(); i++) begin
            waited = 0;
            ok     = 1'b0;
            drive(d, pl[i], 1'b1, i == pl.size() - 1,
                  (i == pl.size() - 1) ? u : 1'($urandom_range(0, 1)));
            while (!ok && waited < 2000) begin
                @(negedge clk);
                ok = s_rdy(d);
                step();
                waited++;
            end
            if (!ok) check("in_timeout", 32'(ok), 32'd1);
        end
        drive(d, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_beats(input int d, input int n);
        int t;
        t = 0;
        while (((d == 0) ? got_pad.size() : got_np.size()) < n && t < 10000) begin
            @(negedge clk);
            t++;
        end
        check("out_timeout", 32'(t < 10000), 32'd1);
        repeat (5) step();
    endtask

    task automatic cmp_q(input string name, input beat_q_t g, input beat_q_t e);
        check({name, "_len"}, 32'(g.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < g.size(); i++)
            check($sformatf("%s_b%0d", name, i), 32'(g[i]), 32'(e[i]));
    endtask

    initial begin
        beat_q_t e;
        byte_q_t p;
        byte_q_t digits;
        int      viol;
        int      lasts;
        logic    u;

        rst = 1'b1;
        drive(0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        @(negedge clk);
        check("rst_tvalid", 32'(mp.tvalid), 32'd0);
        check("rst_sready", 32'(sp.tready), 32'd0);
        check("rst_busy",   32'(busy_pad),  32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rel_sready_pad", 32'(sp.tready), 32'd1);
        check("rel_sready_np",  32'(sn.tready), 32'd1);
        check("rel_tvalid",     32'(mn.tvalid), 32'd0);
        step();

        // Exact CRC on "123456789", no padding.
        digits = {};
        for (int i = 0; i < 9; i++) digits.push_back(8'(8'h31 + i));
        e = {};
        for (int i = 0; i < 9; i++) e.push_back(10'(8'h31 + i));
        e.push_back(10'h026); e.push_back(10'h039); e.push_back(10'h0F4); e.push_back(10'h1CB);
        got_np = {};
        send_frame(1, digits, 1'b0);
        check("np_busy_up", 32'(busy_np), 32'd1);
        wait_beats(1, 13);
        cmp_q("crc9", got_np, e);
        check("np_busy_down", 32'(busy_np), 32'd0);

        // 1-byte frame padded to 64 beats; input stalled during PAD/FCS.
        got_pad = {};
        p = {8'hAA};
        send_frame(0, p, 1'b0);
        check("pad_busy_up", 32'(busy_pad), 32'd1);
        viol = 0;
        for (int i = 0; i < 63; i++) begin
            @(negedge clk);
            if (sp.tready) viol++;
        end
        check("pad_stall", 32'(viol), 32'd0);
        @(negedge clk);
        check("pad_ready_after", 32'(sp.tready), 32'd1);
        step();
        wait_beats(0, 64);
        check("pad_len64", 32'(got_pad.size()), 32'd64);
        e = {};
        build_exp(p, 1'b1, 1'b0, e);
        cmp_q("pad1", got_pad, e);
        check("pad_busy_down", 32'(busy_pad), 32'd0);

        // Boundary: 60 bytes needs no pad, 61 bytes one extra beat.
        for (int len = 60; len <= 61; len++) begin
            p = {};
            for (int i = 0; i < len; i++) p.push_back(8'(i * 7 + 3));
            got_pad = {};
            send_frame(0, p, 1'b0);
            wait_beats(0, len + 4);
            check($sformatf("bnd_len%0d", len), 32'(got_pad.size()), 32'(len + 4));
            e = {};
            build_exp(p, 1'b1, 1'b0, e);
            cmp_q($sformatf("bnd%0d", len), got_pad, e);
        end

        // Bad-frame flag, then a clean frame.
        p = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        for (int k = 0; k < 2; k++) begin
            u = (k == 0);
            got_pad = {};
            send_frame(0, p, u);
            wait_beats(0, 64);
            check($sformatf("bad_user%0d", k), 32'(got_pad[got_pad.size() - 1][9]), 32'(u));
            e = {};
            build_exp(p, 1'b1, u, e);
            cmp_q($sformatf("bad%0d", k), got_pad, e);
        end

        // Random backpressure over 20 back-to-back frames.
        rdy_rand = 1'b1;
        got_pad  = {};
        e        = {};
        for (int f = 0; f < 20; f++) begin
            p = {};
            for (int i = 0; i < $urandom_range(1, 80); i++) p.push_back(8'($urandom));
            u = 1'($urandom_range(0, 1));
            build_exp(p, 1'b1, u, e);
            send_frame(0, p, u);
        end
        wait_beats(0, e.size());
        rdy_rand = 1'b0;
        repeat (3) step();
        cmp_q("bp", got_pad, e);

        // Reset during PAD, then frames on both instances.
        got_pad = {};
        p = {8'h55};
        send_frame(0, p, 1'b1);
        repeat (10) step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("mrst_tvalid", 32'(mp.tvalid), 32'd0);
        check("mrst_tlast",  32'(mp.tlast),  32'd0);
        check("mrst_tuser",  32'(mp.tuser),  32'd0);
        check("mrst_tdata",  32'(mp.tdata),  32'd0);
        check("mrst_sready", 32'(sp.tready), 32'd0);
        check("mrst_busy",   32'(busy_pad),  32'd0);
        check("mrst_np",     32'({mn.tvalid, mn.tlast, mn.tuser, mn.tdata, sn.tready, busy_np}), 32'd0);
        lasts = 0;
        foreach (got_pad[i]) if (got_pad[i][8]) lasts++;
        check("mrst_nolast", 32'(lasts), 32'd0);
        step();
        rst = 1'b0;
        got_pad = {};
        got_np  = {};
        @(negedge clk);
        check("mrst_rel_sready", 32'(sp.tready), 32'd1);
        step();
        send_frame(0, digits, 1'b0);
        wait_beats(0, 64);
        e = {};
        build_exp(digits, 1'b1, 1'b0, e);
        cmp_q("post_rst_pad", got_pad, e);
        send_frame(1, digits, 1'b0);
        wait_beats(1, 13);
        e = {};
        for (int i = 0; i < 9; i++) e.push_back(10'(8'h31 + i));
        e.push_back(10'h026); e.push_back(10'h039); e.push_back(10'h0F4); e.push_back(10'h1CB);
        cmp_q("post_rst_np", got_np, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_fcs_append_ctrl.md
# eth_fcs_append_ctrl

Frame sequencer on the 8-bit AXI4-Stream Ethernet transmit path, ahead of the GMII/MII framer. It passes payload bytes through, optionally zero-pads short frames to the Ethernet minimum, and appends the 4-byte FCS. It owns and sequences one CRC-32 engine: init, per-byte update, finalise.

## Interface
- `ENABLE_PADDING`, default 1: zero-pad frames shorter than `MIN_FRAME_LENGTH`.
- `MIN_FRAME_LENGTH`, default 64: minimum frame length in bytes, including FCS; must be ≥ 5.
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_axis_tdata`  in  8  payload byte.
- `s_axis_tvalid`  in  1  payload valid.
- `s_axis_tready`  out  1  payload accept.
- `s_axis_tlast`  in  1  last payload byte.
- `s_axis_tuser`  in  1  bad-frame flag; sampled with `tlast`.
- `m_axis_tdata`  out  8  output byte: payload, pad or FCS.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  downstream accept.
- `m_axis_tlast`  out  1  last byte of the frame; always the final FCS byte.
- `m_axis_tuser`  out  1  bad-frame flag; asserted only with `m_axis_tlast`.
- `busy`  out  1  high from first accepted byte through the final FCS handshake.

## Operation
- **States:**
  - `IDLE`: waiting for a frame.
  - `PAYLOAD`: passing input bytes.
  - `PAD`: emitting `0x00` bytes.
  - `FCS`: emitting 4 FCS bytes.
- **Output register:** a single register `out_*` holds the current output beat.
  - It loads when `!m_axis_tvalid || m_axis_tready` (the "load" condition).
  - `s_axis_tready` = load condition AND state ∈ {`IDLE`, `PAYLOAD`}.
- **Payload bytes:**
  - Each accepted input byte is copied to the output register.
  - The CRC state is updated with that byte. The CRC is reflected CRC-32: poly 0x04C11DB7, init 0xFFFFFFFF, LSB-first.
  - `byte_cnt` increments on each byte and saturates at `MIN_FRAME_LENGTH-4`.
  - The first byte moves `IDLE` → `PAYLOAD`.
- **On accepted `tlast`:**
  - Latch `s_axis_tuser` into `bad_reg`.
  - If `ENABLE_PADDING` and `byte_cnt+1 < MIN_FRAME_LENGTH-4`, go to `PAD`. Otherwise go to `FCS` with `fcs_idx`=0.
- **PAD:** on each load, emit `0x00` and run the CRC update on it. Leave for `FCS` when the payload+pad count reaches `MIN_FRAME_LENGTH-4`.
- **FCS:**
  - On entry, latch `fcs_reg = ~crc_state`.
  - On each load, emit `fcs_reg[8*fcs_idx +: 8]` (LSB byte first).
  - At `fcs_idx`=3, also assert `m_axis_tlast`, drive `m_axis_tuser`=`bad_reg`, reinit the CRC to 0xFFFFFFFF, clear `byte_cnt`, and go to `IDLE`.
- **Widths:**
  - `byte_cnt` is `$clog2(MIN_FRAME_LENGTH)+1` bits.
  - `fcs_idx` is 2 bits and never wraps, because the exit is at 3.
- **`tuser` without `tlast`:** ignored.
- **Zero-length frames:** impossible, since a frame starts with a valid byte.
- **`rst` at any cycle, mid-frame included:**
  - State → `IDLE`, CRC → 0xFFFFFFFF, counters cleared.
  - All outputs 0: `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tuser`, `m_axis_tdata`, `s_axis_tready`, `busy`.
  - The partial frame is dropped with no `tlast` emitted.

## Timing
- **Latency:** 1 cycle from input handshake to output valid.
- **Full throughput:** 1 byte/cycle when `m_axis_tready`=1.
- **Input stall:** `s_axis_tready` is low throughout `PAD`/`FCS`.
- **Gap to next frame:**
  - The next frame is accepted in the cycle after the final FCS byte is loaded into the output register.
  - The minimum input gap is therefore pad count + 4 cycles.
- **Backpressure:** while `m_axis_tvalid && !m_axis_tready`, all outputs hold stable, and the CRC and counters do not advance.
- **`busy` timing:** `busy` rises the cycle after the first input handshake. It falls the cycle after the `tlast` output handshake.
- **First cycle after reset release:** `s_axis_tready`=1 if `m_axis_tready` is irrelevant (output empty).

## Structure
- **Shared package:** state encoding (`ST_IDLE`, `ST_PAYLOAD`, `ST_PAD`, `ST_FCS`) and the constants `CRC32_POLY`=32'h04C11DB7 and `CRC32_INIT`=32'hFFFFFFFF.
- **Sub-module:** one instance of the existing `ve_lfsr`, configured as:
  - 32 bit, GALOIS, `REVERSE`=1, `DATA_WIDTH`=8, no feed-forward.
  - Combinational. `state_in` is `crc_state`; the data input is muxed between payload and `0x00`.

## Test plan
- **Exact CRC:** `ENABLE_PADDING`=0, input "123456789" (`31..39`) → 9 data bytes, then `26 39 F4 CB` with `tlast` on `CB`, `tuser`=0.
- **Padding:** `ENABLE_PADDING`=1, 1-byte frame `0xAA` → 64 output beats: `AA`, 59×`00`, 4 FCS bytes equal to the reference model CRC; `tlast` only on beat 64; `s_axis_tready`=0 for beats 2–64.
- **No padding at the boundary:** 60-byte frame → exactly 64 beats, no pad. 61-byte frame → 65 beats.
- **Bad frame:** `tuser`=1 on the input `tlast` → `m_axis_tuser`=1 only on the final FCS beat. Next frame `tuser`=0 → 0.
- **Backpressure:** random `m_axis_tready` (50%) over 20 back-to-back random frames → byte-exact match to the model; output held stable while stalled.
- **Reset mid-frame:** `rst` during `PAD` → next cycle all outputs 0. A following "123456789" frame still yields FCS `CBF43926`.
